xnor_neuron_acc: RTL and testbench
==================================

XNOR_NEURON_ACC -- requirements
Module: xnor_neuron_acc

Interface
REQ-001 SHALL have parameter INPUTS, default 8, meaning synapse inputs per frame (>=2).
REQ-002 SHALL have parameter BIAS_BITS, default 4, meaning threshold width (>=2).
REQ-003 SHALL have parameter FRAMES, default 4, meaning input frames accumulated per inference (>=1).
REQ-004 SHALL derive localparam ACC_BITS = $clog2(INPUTS*FRAMES+1).
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 setup  input  1  parameter-chain shift enable.
REQ-008 param_in  input  1  serial parameter input.
REQ-009 param_out  output  1  serial parameter output, equals bias[BIAS_BITS-1].
REQ-010 in_valid  input  1  input frame valid.
REQ-011 in_ready  output  1  frame accepted when in_valid && in_ready.
REQ-012 inputs  input  INPUTS  binary activation frame.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-015 axon  output  1  neuron decision, meaningful while out_valid.
REQ-016 count  output  ACC_BITS  accumulated popcount, meaningful while out_valid.

Function
REQ-017 SHALL hold registers weights[INPUTS-1:0], bias[BIAS_BITS-1:0], acc[ACC_BITS-1:0], frame counter, two-state FSM {COLLECT, HOLD}, axon, count.
REQ-018 When setup=1, SHALL shift per cycle: weights <= {weights[INPUTS-2:0], param_in}, bias <= {bias[BIAS_BITS-2:0], weights[INPUTS-1]}; chain loads MSB-first, bias bits first, INPUTS+BIAS_BITS cycles total.
REQ-019 setup SHALL take priority over all datapath activity: in the same edge acc, frame counter cleared, FSM -> COLLECT, out_valid -> 0; any frame presented that cycle is dropped.
REQ-020 in_ready SHALL be 1 only when FSM=COLLECT and setup=0.
REQ-021 Synapse vector SHALL be weights & inputs (default) or per REQ-031 with XNOR mode.
REQ-022 On each accepted frame SHALL add popcount(synapses) to acc, increment frame counter.
REQ-023 On acceptance of frame FRAMES (counter = FRAMES-1), SHALL on that edge register count = acc + popcount, axon = (acc + popcount) > bias (unsigned, bias zero-extended to max(ACC_BITS,BIAS_BITS)), clear acc and counter, FSM -> HOLD; out_valid visible next cycle (1-cycle latency).
REQ-024 In HOLD, out_valid=1; axon, count stable; in_ready=0 until out_ready=1.
REQ-025 On out handshake SHALL FSM -> COLLECT; in_ready=1 next cycle.
REQ-026 axon SHALL be 0 when sum equals bias (strictly greater).
REQ-027 FRAMES=1: every accepted frame produces a result; counter SHALL never exceed FRAMES-1.
REQ-028 weights/bias SHALL be unchanged unless setup=1.

Reset
REQ-029 rst_n=0 SHALL asynchronously clear weights, bias, acc, frame counter, count, axon, out_valid; FSM = COLLECT; param_out=0; in_ready=1 after release (setup=0).
REQ-030 Reset asserted mid-inference or in HOLD SHALL discard partial sums and pending result.

Configuration
REQ-031 Macro NEURON_XNOR_EN: defined -> synapses = ~(weights ^ inputs) (bipolar XNOR match); undefined -> synapses = weights & inputs; interface, latency, handshake identical in both builds.

Verification (INPUTS=8, BIAS_BITS=4, FRAMES=4)
REQ-032 Reset: rst_n=0 mid-run -> out_valid=0, axon=0, count=0, param_out=0; after release in_ready=1.
REQ-033 Shift bias=3 then weights=0xFF (12 setup cycles); frames 0x0F,0x00,0x00,0x00 -> next cycle out_valid=1, count=4, axon=1.
REQ-034 Same with bias=4 -> count=4, axon=0; chain read-back: 12 further setup cycles yield bias bits 0100 on param_out MSB-first.
REQ-035 out_ready=0 for 5 cycles in HOLD -> out_valid, axon, count stable, in_ready=0, in_valid frames ignored; out_ready=1 -> in_ready=1 next cycle.
REQ-036 After 2 accepted frames assert setup 1 cycle -> acc cleared; result only after 4 further frames, count excludes earlier frames.
REQ-037 weights=0xF0, bias=15, four frames 0x00 -> without NEURON_XNOR_EN count=0, axon=0; with it count=16, axon=1.

Source files
------------

// File: rtl/xnor_neuron_acc.sv
// Binary neuron: serially-loaded weights/bias, popcount accumulation over FRAMES frames, threshold decision.
// Optional macro NEURON_XNOR_EN selects XNOR (bipolar) synapses instead of AND synapses.
module xnor_neuron_acc #(
  parameter  int INPUTS    = 8,
  parameter  int BIAS_BITS = 4,
  parameter  int FRAMES    = 4,
  localparam int ACC_BITS  = $clog2(INPUTS*FRAMES+1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                setup,
  input  logic                param_in,
  output logic                param_out,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INPUTS-1:0]   inputs,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                axon,
  output logic [ACC_BITS-1:0] count
);
  localparam int CNT_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int CMP_W = (ACC_BITS > BIAS_BITS) ? ACC_BITS : BIAS_BITS;
  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  logic [INPUTS-1:0]    weights;
  logic [BIAS_BITS-1:0] bias;
  logic [ACC_BITS-1:0]  acc;
  logic [CNT_W-1:0]     fcnt;
  logic [0:0]           state;
  logic [INPUTS-1:0]    syn;
  logic [ACC_BITS-1:0]  pc;
  logic [ACC_BITS-1:0]  sum;
  logic                 accept;
  logic                 last;

  for (genvar i = 0; i < INPUTS; i++) begin : g_syn
`ifdef NEURON_XNOR_EN
    assign syn[i] = ~(weights[i] ^ inputs[i]);
`else
    assign syn[i] = weights[i] & inputs[i];
`endif
  end

  always_comb begin
    pc = '0;
    for (int i = 0; i < INPUTS; i++) pc = pc + ACC_BITS'(syn[i]);
  end

  // acc + pc never exceeds INPUTS*FRAMES, so ACC_BITS cannot overflow
  assign sum       = acc + pc;
  assign in_ready  = (state == COLLECT) && !setup;
  assign accept    = in_valid && in_ready;
  assign last      = (fcnt == CNT_W'(FRAMES-1));
  assign out_valid = (state == HOLD);
  assign param_out = bias[BIAS_BITS-1];

  // Parameter chain: param_in -> weights LSB ... weights MSB -> bias LSB ... bias MSB -> param_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weights <= '0;
      bias    <= '0;
    end else if (setup) begin
      weights <= {weights[INPUTS-2:0], param_in};
      bias    <= {bias[BIAS_BITS-2:0], weights[INPUTS-1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      fcnt  <= '0;
      state <= COLLECT;
      count <= '0;
      axon  <= 1'b0;
    end else if (setup) begin
      acc   <= '0;
      fcnt  <= '0;
      state <= COLLECT;
    end else if (state == HOLD) begin
      if (out_ready) state <= COLLECT;
    end else if (accept) begin
      if (last) begin
        count <= sum;
        axon  <= CMP_W'(sum) > CMP_W'(bias);
        acc   <= '0;
        fcnt  <= '0;
        state <= HOLD;
      end else begin
        acc  <= sum;
        fcnt <= fcnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_xnor_neuron_acc.sv
// Randomized self-checking bench for xnor_neuron_acc (INPUTS=8, BIAS_BITS=4, FRAMES=4) against a frame-sum model.
module tb_xnor_neuron_acc;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       setup = 1'b0;
  logic       param_in = 1'b0;
  logic       param_out;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] inputs = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       axon;
  logic [5:0] count;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: 12-bit chain {bias, weights}, running sum of frame popcounts
  logic [11:0] chain = '0;
  int m_acc = 0;
  int m_n = 0;
  int exp_count = 0;
  logic exp_axon = 1'b0;

  xnor_neuron_acc dut (
    .clk(clk), .rst_n(rst_n), .setup(setup), .param_in(param_in), .param_out(param_out),
    .in_valid(in_valid), .in_ready(in_ready), .inputs(inputs), .out_valid(out_valid),
    .out_ready(out_ready), .axon(axon), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] syn_f(input logic [7:0] w, input logic [7:0] x);
`ifdef NEURON_XNOR_EN
    return ~(w ^ x);
`else
    return w & x;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [11:0] v, output logic [11:0] rd);
    for (int i = 11; i >= 0; i--) begin
      setup = 1'b1;
      param_in = v[i];
      rd[i] = param_out;
      tick();
    end
    setup = 1'b0;
    chain = v;
    m_acc = 0;
    m_n = 0;
  endtask

  task automatic send_frame(input logic [7:0] x);
    int t;
    t = 0;
    while (!in_ready && t < 20) begin tick(); t++; end
    if (!in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL in_ready_timeout: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1;
    inputs = x;
    tick();
    in_valid = 1'b0;
    m_acc += $countones(syn_f(chain[7:0], x));
    m_n++;
    if (m_n == 4) begin
      exp_count = m_acc;
      exp_axon = (m_acc > int'(chain[11:8]));
      m_acc = 0;
      m_n = 0;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] rd;
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (param_out !== 1'b0) begin n_fail++; $display("FAIL rst_param_out: got %0b want 0", param_out); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
    // Mid-inference reset with a nonzero bias loaded
    load(12'hAFF, rd);
    send_frame(8'hFF);
    send_frame(8'h3C);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || axon !== 1'b0 || count !== 6'd0 || param_out !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs: ov=%0b axon=%0b count=%0d po=%0b want 0/0/0/0", out_valid, axon, count, param_out); end
    chain = '0; m_acc = 0; m_n = 0;
    rst_n = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_bias3();
    logic [11:0] rd;
    load({4'd3, 8'hFF}, rd);
    send_frame(8'h0F); send_frame(8'h00); send_frame(8'h00); send_frame(8'h00);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b3_out_valid: got %0b want 1", out_valid); end
    n_cmp++; if (count !== 6'd4 || count !== 6'(exp_count)) begin n_fail++; $display("FAIL b3_count: got %0d want 4", count); end
    n_cmp++; if (axon !== 1'b1) begin n_fail++; $display("FAIL b3_axon: got %0b want 1", axon); end
    pop();
  endtask

  task automatic test_bias4_readback();
    logic [11:0] rd;
    load({4'd4, 8'hFF}, rd);
    send_frame(8'h0F); send_frame(8'h00); send_frame(8'h00); send_frame(8'h00);
    n_cmp++; if (count !== 6'd4) begin n_fail++; $display("FAIL b4_count: got %0d want 4", count); end
    n_cmp++; if (axon !== 1'b0) begin n_fail++; $display("FAIL b4_axon: got %0b want 0", axon); end
    pop();
    load({4'd4, 8'hFF}, rd);
    n_cmp++; if (rd[11:8] !== 4'b0100) begin n_fail++; $display("FAIL readback_bias: got %b want 0100", rd[11:8]); end
    n_cmp++; if (rd[7:0] !== 8'hFF) begin n_fail++; $display("FAIL readback_weights: got %h want ff", rd[7:0]); end
  endtask

  task automatic test_hold();
    logic [11:0] rd;
    load({4'd5, 8'hA5}, rd);
    for (int i = 0; i < 4; i++) send_frame(8'($urandom));
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      inputs = 8'hFF;
      out_ready = 1'b0;
      tick();
      n_cmp++; if (out_valid !== 1'b1 || count !== 6'(exp_count) || axon !== exp_axon || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL hold_stable: ov=%0b count=%0d axon=%0b ir=%0b want 1/%0d/%0b/0", out_valid, count, axon, in_ready, exp_count, exp_axon); end
    end
    in_valid = 1'b0;
    pop();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL hold_release: ov=%0b ir=%0b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_random();
    logic [11:0] rd;
    for (int n = 0; n < 25; n++) begin
      if (n % 5 == 0) load(12'($urandom), rd);
      for (int f = 0; f < 4; f++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) begin inputs = 8'($urandom); tick(); end
        send_frame(8'($urandom));
      end
      for (int d = $urandom_range(0, 3); d > 0; d--) tick();
      n_cmp++; if (out_valid !== 1'b1 || count !== 6'(exp_count) || axon !== exp_axon) begin
        n_fail++; $display("FAIL rand_result[%0d]: ov=%0b count=%0d axon=%0b want 1/%0d/%0b", n, out_valid, count, axon, exp_count, exp_axon); end
      pop();
    end
  endtask

  task automatic test_setup_abort();
    logic [11:0] rd;
    load({4'd6, 8'h5A}, rd);
    send_frame(8'hFF);
    send_frame(8'hFF);
    // One setup cycle with a frame presented: frame dropped, chain shifts by one bit
    setup = 1'b1; param_in = 1'b1; in_valid = 1'b1; inputs = 8'hFF;
    tick();
    setup = 1'b0; in_valid = 1'b0;
    chain = {chain[10:0], 1'b1};
    m_acc = 0; m_n = 0;
    for (int i = 0; i < 3; i++) begin
      send_frame(8'($urandom));
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_early_result: ov=%0b want 0", out_valid); end
    end
    send_frame(8'($urandom));
    n_cmp++; if (out_valid !== 1'b1 || count !== 6'(exp_count) || axon !== exp_axon) begin
      n_fail++; $display("FAIL abort_result: ov=%0b count=%0d axon=%0b want 1/%0d/%0b", out_valid, count, axon, exp_count, exp_axon); end
    pop();
  endtask

  task automatic test_zero_frames();
    logic [11:0] rd;
    load({4'd15, 8'hF0}, rd);
    for (int i = 0; i < 4; i++) send_frame(8'h00);
`ifdef NEURON_XNOR_EN
    n_cmp++; if (count !== 6'd16 || axon !== 1'b1) begin n_fail++; $display("FAIL zero_frames: count=%0d axon=%0b want 16/1", count, axon); end
`else
    n_cmp++; if (count !== 6'd0 || axon !== 1'b0) begin n_fail++; $display("FAIL zero_frames: count=%0d axon=%0b want 0/0", count, axon); end
`endif
    pop();
  endtask

  initial begin
    test_reset();
    test_bias3();
    test_bias4_readback();
    test_hold();
    test_random();
    test_setup_abort();
    test_zero_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
